// File: rtl/stream_demux.sv
// stream_demux -- registered 1-to-N valid/ready stream demultiplexer.
//
// One input stream is steered, beat by beat, to one of N output channels
// chosen by in_sel. A single output register stage holds the beat. A new
// beat can be accepted in the same cycle that the held one is taken, so
// back-to-back transfers run at one beat per cycle, including when the
// destination channel changes between beats.
//
// Parameters
//   WIDTH  data bits per beat
//   N      number of output channels (2..16)
//   SEL_W  select width, 2**SEL_W >= N
//
// Ports
//   clk        rising-edge clock
//   rst        synchronous, active-high reset
//   in_valid   input beat valid
//   in_ready   block can accept a beat this cycle (from state and out_ready only)
//   in_data    input payload
//   in_sel     destination channel of the input beat
//   out_valid  one-hot valid, bit k = held beat is for channel k
//   out_ready  per-channel consumer ready (only the selected bit matters)
//   out_data   held payload, shared by all channels
//   xfer_cnt   completed output transfers
//
// Build option
//   STREAM_DEMUX_STATS_EN  when defined, xfer_cnt counts output handshakes
//                          (wrapping, cleared by rst); otherwise it is 0.

module stream_demux #(
   parameter int WIDTH = 8,
   parameter int N     = 4,
   parameter int SEL_W = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_data,
   input  logic [SEL_W-1:0] in_sel,
   output logic [N-1:0]     out_valid,
   input  logic [N-1:0]     out_ready,
   output logic [WIDTH-1:0] out_data,
   output logic [15:0]      xfer_cnt
);

   typedef enum logic {
      EMPTY_S = 1'b0,
      FULL_S  = 1'b1
   } state_t;

   // Decode a channel number into a one-hot channel vector.
   function automatic logic [N-1:0] onehot(input logic [SEL_W-1:0] s);
      logic [N-1:0] v;
      for (int k = 0; k < N; k++) begin
         v[k] = (int'(s) == k);
      end
      return v;
   endfunction

   state_t           state_r;
   state_t           state_s;
   logic [WIDTH-1:0] data_r;
   logic [SEL_W-1:0] sel_r;
   logic [N-1:0]     valid_r;
   logic [N-1:0]     valid_s;
   logic             sel_ready_s;
   logic             in_ready_s;
   logic             in_range_s;
   logic             load_s;
   logic             out_hs_s;

   // Handshake decode and next-state selection.
   always_comb begin
      state_s     = state_r;
      valid_s     = valid_r;
      // sel_r is only ever loaded with an in-range channel, so this index is valid.
      sel_ready_s = out_ready[sel_r];
      in_ready_s  = !rst && ((state_r == EMPTY_S) || sel_ready_s);
      in_range_s  = (int'(in_sel) < N);
      // Out-of-range beats are accepted by the handshake but never loaded.
      load_s      = in_valid && in_ready_s && in_range_s;
      out_hs_s    = (state_r == FULL_S) && sel_ready_s;

      case (state_r)
         EMPTY_S: begin
            if (load_s) begin
               state_s = FULL_S;
               valid_s = onehot(in_sel);
            end else begin
               state_s = EMPTY_S;
               valid_s = '0;
            end
         end
         FULL_S: begin
            if (load_s) begin
               state_s = FULL_S;
               valid_s = onehot(in_sel);
            end else if (out_hs_s) begin
               state_s = EMPTY_S;
               valid_s = '0;
            end else begin
               state_s = FULL_S;
               valid_s = valid_r;
            end
         end
         default: begin
            state_s = EMPTY_S;
            valid_s = '0;
         end
      endcase
   end

   // Holding register: state, payload, channel and registered one-hot valid.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r <= EMPTY_S;
         data_r  <= '0;
         sel_r   <= '0;
         valid_r <= '0;
      end else begin
         state_r <= state_s;
         valid_r <= valid_s;
         if (load_s) begin
            data_r <= in_data;
            sel_r  <= in_sel;
         end
      end
   end

   assign in_ready  = in_ready_s;
   assign out_valid = valid_r;
   assign out_data  = data_r;

`ifdef STREAM_DEMUX_STATS_EN
   logic [15:0] cnt_r;

   // Output handshake counter, wraps naturally at 16 bits.
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_r <= 16'h0000;
      end else if (out_hs_s) begin
         cnt_r <= cnt_r + 16'h0001;
      end
   end

   assign xfer_cnt = cnt_r;
`else
   assign xfer_cnt = 16'h0000;
`endif

endmodule

// File: tb/tb_stream_demux.sv
// Self-checking bench for stream_demux. Two instances share one stimulus
// stream: inst A with N=4 and inst B with N=3 (so select 3 is out of range
// for B). A transaction-level model tracks the beat each instance holds.

module tb_stream_demux;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst;
   logic       in_valid;
   logic [7:0] in_data;
   logic [1:0] in_sel;
   logic [3:0] out_ready;

   logic       a_in_ready;
   logic [3:0] a_out_valid;
   logic [7:0] a_out_data;
   logic [15:0] a_xfer;

   logic       b_in_ready;
   logic [2:0] b_out_valid;
   logic [7:0] b_out_data;
   logic [15:0] b_xfer;

   int n_pass  = 0;
   int n_total = 0;

   stream_demux #(.WIDTH(8), .N(4), .SEL_W(2)) dut_a (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(a_in_ready),
      .in_data(in_data), .in_sel(in_sel), .out_valid(a_out_valid),
      .out_ready(out_ready), .out_data(a_out_data), .xfer_cnt(a_xfer)
   );

   stream_demux #(.WIDTH(8), .N(3), .SEL_W(2)) dut_b (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(b_in_ready),
      .in_data(in_data), .in_sel(in_sel), .out_valid(b_out_valid),
      .out_ready(out_ready[2:0]), .out_data(b_out_data), .xfer_cnt(b_xfer)
   );

`ifdef STREAM_DEMUX_STATS_EN
   localparam bit STATS = 1'b1;
`else
   localparam bit STATS = 1'b0;
`endif

   // Reference model: each instance either holds one beat or nothing.
   logic        m_full [2];
   logic [7:0]  m_data [2];
   logic [1:0]  m_sel  [2];
   logic [15:0] m_cnt  [2];

   function automatic int m_n(input int i);
      return (i == 0) ? 4 : 3;
   endfunction

   function automatic logic exp_ready(input int i);
      return !rst && (!m_full[i] || out_ready[m_sel[i]]);
   endfunction

   function automatic logic [3:0] exp_valid(input int i);
      return m_full[i] ? (4'b0001 << m_sel[i]) : 4'b0000;
   endfunction

   function automatic logic [15:0] exp_cnt(input int i);
      return STATS ? m_cnt[i] : 16'h0000;
   endfunction

   task automatic drive(input logic r, input logic v, input logic [7:0] d,
                        input logic [1:0] s, input logic [3:0] o);
      rst = r; in_valid = v; in_data = d; in_sel = s; out_ready = o;
      #1;
   endtask

   // Advance one clock and move the model along with it.
   task automatic tick();
      logic rd [2];
      logic ohs [2];
      for (int i = 0; i < 2; i++) begin
         rd[i]  = exp_ready(i);
         ohs[i] = m_full[i] && out_ready[m_sel[i]];
      end
      @(posedge clk);
      for (int i = 0; i < 2; i++) begin
         if (rst) begin
            m_full[i] = 1'b0; m_data[i] = 8'h00; m_sel[i] = 2'd0; m_cnt[i] = 16'h0000;
         end else begin
            if (ohs[i]) m_cnt[i] = m_cnt[i] + 16'h0001;
            if (in_valid && rd[i] && (int'(in_sel) < m_n(i))) begin
               m_full[i] = 1'b1; m_data[i] = in_data; m_sel[i] = in_sel;
            end else if (ohs[i]) begin
               m_full[i] = 1'b0;
            end
         end
      end
      #1;
   endtask

   task automatic test_reset();
      drive(1'b1, 1'b1, 8'hC3, 2'd1, 4'hF);
      tick();
      n_total++;
      if ({a_in_ready, a_out_valid, a_out_data, a_xfer} !== {1'b0, 4'b0000, 8'h00, 16'h0000})
         $display("FAIL reset_hold: got rdy=%b v=%b d=%h c=%h want 0/0000/00/0000",
                  a_in_ready, a_out_valid, a_out_data, a_xfer);
      else n_pass++;
      tick();
      n_total++;
      if ({b_in_ready, b_out_valid, b_out_data, b_xfer} !== {1'b0, 3'b000, 8'h00, 16'h0000})
         $display("FAIL reset_hold_b: got rdy=%b v=%b d=%h c=%h want 0/000/00/0000",
                  b_in_ready, b_out_valid, b_out_data, b_xfer);
      else n_pass++;
      drive(1'b0, 1'b0, 8'h00, 2'd0, 4'hF);
      n_total++;
      if ({a_in_ready, b_in_ready, a_out_valid} !== {1'b1, 1'b1, 4'b0000})
         $display("FAIL reset_release: got rdyA=%b rdyB=%b v=%b want 1/1/0000",
                  a_in_ready, b_in_ready, a_out_valid);
      else n_pass++;
   endtask

   task automatic test_routes();
      logic [7:0] dt [4] = '{8'hA5, 8'h3C, 8'h0F, 8'hF0};
      logic [3:0] vt [4] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000};
      for (int k = 0; k <= 4; k++) begin
         drive(1'b0, (k < 4), (k < 4) ? dt[k % 4] : 8'h00, 2'(k % 4), 4'hF);
         if (k > 0) begin
            n_total++;
            if ({a_in_ready, a_out_valid, a_out_data} !== {1'b1, vt[k-1], dt[k-1]})
               $display("FAIL route_%0d: got rdy=%b v=%b d=%h want 1/%b/%h",
                        k - 1, a_in_ready, a_out_valid, a_out_data, vt[k-1], dt[k-1]);
            else n_pass++;
         end
         tick();
      end
      drive(1'b0, 1'b0, 8'h00, 2'd0, 4'hF);
      n_total++;
      if ({a_out_valid, a_xfer} !== {4'b0000, (STATS ? 16'd4 : 16'd0)})
         $display("FAIL route_count: got v=%b cnt=%0d want 0000/%0d",
                  a_out_valid, a_xfer, STATS ? 4 : 0);
      else n_pass++;
   endtask

   task automatic test_backpressure();
      drive(1'b0, 1'b1, 8'h55, 2'd2, 4'hF);
      tick();
      for (int k = 0; k < 3; k++) begin
         drive(1'b0, 1'b1, 8'h66, 2'd1, 4'b0001);
         n_total++;
         if ({a_in_ready, a_out_valid, a_out_data} !== {1'b0, 4'b0100, 8'h55})
            $display("FAIL bp_stall_%0d: got rdy=%b v=%b d=%h want 0/0100/55",
                     k, a_in_ready, a_out_valid, a_out_data);
         else n_pass++;
         tick();
      end
      drive(1'b0, 1'b1, 8'h66, 2'd1, 4'hF);
      n_total++;
      if ({a_in_ready, a_out_valid, a_out_data} !== {1'b1, 4'b0100, 8'h55})
         $display("FAIL bp_release: got rdy=%b v=%b d=%h want 1/0100/55",
                  a_in_ready, a_out_valid, a_out_data);
      else n_pass++;
      tick();
      drive(1'b0, 1'b0, 8'h00, 2'd0, 4'hF);
      n_total++;
      if ({a_out_valid, a_out_data, a_xfer} !== {4'b0010, 8'h66, exp_cnt(0)})
         $display("FAIL bp_next: got v=%b d=%h c=%0d want 0010/66/%0d",
                  a_out_valid, a_out_data, a_xfer, exp_cnt(0));
      else n_pass++;
      tick();
   endtask

   task automatic test_out_of_range();
      drive(1'b1, 1'b0, 8'h00, 2'd0, 4'hF);
      tick();
      drive(1'b0, 1'b1, 8'h99, 2'd3, 4'hF);
      n_total++;
      if (b_in_ready !== 1'b1)
         $display("FAIL oor_accept: got rdy=%b want 1", b_in_ready);
      else n_pass++;
      tick();
      for (int k = 0; k < 2; k++) begin
         drive(1'b0, 1'b0, 8'h00, 2'd0, 4'hF);
         n_total++;
         if ({b_in_ready, b_out_valid, b_out_data, b_xfer} !== {1'b1, 3'b000, 8'h00, 16'h0000})
            $display("FAIL oor_drop_%0d: got rdy=%b v=%b d=%h c=%0d want 1/000/00/0",
                     k, b_in_ready, b_out_valid, b_out_data, b_xfer);
         else n_pass++;
         tick();
      end
      drive(1'b0, 1'b1, 8'h12, 2'd0, 4'hF);
      tick();
      drive(1'b0, 1'b0, 8'h00, 2'd0, 4'hF);
      n_total++;
      if ({b_out_valid, b_out_data} !== {3'b001, 8'h12})
         $display("FAIL oor_next: got v=%b d=%h want 001/12", b_out_valid, b_out_data);
      else n_pass++;
   endtask

   task automatic test_reset_mid();
      drive(1'b0, 1'b1, 8'h77, 2'd1, 4'hF);
      tick();
      drive(1'b0, 1'b0, 8'h00, 2'd0, 4'b1101);
      n_total++;
      if ({a_in_ready, a_out_valid, a_out_data} !== {1'b0, 4'b0010, 8'h77})
         $display("FAIL rmid_blocked: got rdy=%b v=%b d=%h want 0/0010/77",
                  a_in_ready, a_out_valid, a_out_data);
      else n_pass++;
      tick();
      drive(1'b1, 1'b0, 8'h00, 2'd0, 4'hF);
      tick();
      drive(1'b0, 1'b0, 8'h00, 2'd0, 4'hF);
      n_total++;
      if ({a_in_ready, a_out_valid, a_out_data, a_xfer} !== {1'b1, 4'b0000, 8'h00, 16'h0000})
         $display("FAIL rmid_after: got rdy=%b v=%b d=%h c=%0d want 1/0000/00/0",
                  a_in_ready, a_out_valid, a_out_data, a_xfer);
      else n_pass++;
   endtask

   task automatic test_random();
      for (int k = 0; k < 3000; k++) begin
         drive(($urandom_range(0, 99) == 0), ($urandom_range(0, 3) != 0),
               8'($urandom), 2'($urandom), 4'($urandom_range(0, 15)));
         n_total++;
         if ({a_in_ready, a_out_valid, a_out_data, a_xfer} !==
             {exp_ready(0), exp_valid(0), m_data[0], exp_cnt(0)})
            $display("FAIL rand_a @%0d: got rdy=%b v=%b d=%h c=%0d want %b/%b/%h/%0d",
                     k, a_in_ready, a_out_valid, a_out_data, a_xfer,
                     exp_ready(0), exp_valid(0), m_data[0], exp_cnt(0));
         else n_pass++;
         n_total++;
         if ({b_in_ready, 1'b0, b_out_valid, b_out_data, b_xfer} !==
             {exp_ready(1), exp_valid(1), m_data[1], exp_cnt(1)})
            $display("FAIL rand_b @%0d: got rdy=%b v=%b d=%h c=%0d want %b/%b/%h/%0d",
                     k, b_in_ready, b_out_valid, b_out_data, b_xfer,
                     exp_ready(1), exp_valid(1), m_data[1], exp_cnt(1));
         else n_pass++;
         tick();
      end
   endtask

   task automatic test_counter_wrap();
      drive(1'b1, 1'b0, 8'h00, 2'd0, 4'hF);
      tick();
      // 65536 beats back to back: 65535 of them have left the block.
      for (int k = 0; k < 65536; k++) begin
         drive(1'b0, 1'b1, 8'($urandom), 2'($urandom), 4'hF);
         tick();
      end
      drive(1'b0, 1'b0, 8'h00, 2'd0, 4'hF);
      n_total++;
      if ({a_out_valid != 4'b0000, a_xfer} !== {1'b1, (STATS ? 16'hFFFF : 16'h0000)})
         $display("FAIL wrap_pre: got v=%b c=%h want held/%h",
                  a_out_valid, a_xfer, STATS ? 16'hFFFF : 16'h0000);
      else n_pass++;
      tick();
      n_total++;
      if ({a_out_valid, a_xfer} !== {4'b0000, 16'h0000})
         $display("FAIL wrap_post: got v=%b c=%h want 0000/0000", a_out_valid, a_xfer);
      else n_pass++;
   endtask

   initial begin
      for (int i = 0; i < 2; i++) begin
         m_full[i] = 1'b0; m_data[i] = 8'h00; m_sel[i] = 2'd0; m_cnt[i] = 16'h0000;
      end
      rst = 1'b1; in_valid = 1'b0; in_data = 8'h00; in_sel = 2'd0; out_ready = 4'h0;
      test_reset();
      test_routes();
      test_backpressure();
      test_out_of_range();
      test_reset_mid();
      test_random();
      test_counter_wrap();
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
